// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  // Step-counter width for an arbitrary operand width (must count down from w).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/add_n.sv
// N-bit ripple-carry adder, generalisation of the 4-bit adder cell.
module add_n #(
  parameter int N = 4
) (
  input  logic         carryin,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] S,
  output logic         carryout
);

  logic [N:0] c;

  always_comb begin
    S    = '0;
    c    = '0;
    c[0] = carryin;
    for (int unsigned i = 0; i < N; i++) begin
      S[i]   = X[i] ^ Y[i] ^ c[i];
      c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
    end
    carryout = c[N];
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one WIDTH-bit adder reused for WIDTH steps,
// unsigned or two's-complement operands selected per operation.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q, acc_hi_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q, busy_q, done_q;
  logic [2*WIDTH-1:0] product_q;

  logic               sgn_en_d, neg_d;
  logic [WIDTH-1:0]   a_abs_d, b_abs_d, addend_d, sum_s_d;
  logic               sum_co_d;
  logic [2*WIDTH-1:0] mag_d, product_d;

  // Magnitudes of the operands; the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    sgn_en_d = signed_mode && SIGNED_EN;
    a_abs_d  = (sgn_en_d && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_abs_d  = (sgn_en_d && b[WIDTH-1]) ? (~b + 1'b1) : b;
    neg_d    = sgn_en_d && (a[WIDTH-1] ^ b[WIDTH-1]);
    addend_d = mplier_q[0] ? mcand_q : '0;
  end

  add_n #(.N(WIDTH)) u_add (
    .carryin (1'b0),
    .X       (acc_hi_q),
    .Y       (addend_d),
    .S       (sum_s_d),
    .carryout(sum_co_d)
  );

  // Zero magnitude is never negated, so no negative-zero artefact can appear.
  always_comb begin
    mag_d     = {acc_hi_q, mplier_q};
    product_d = (neg_q && (|mag_d)) ? (~mag_d + 1'b1) : mag_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= a_abs_d;
            mplier_q <= b_abs_d;
            acc_hi_q <= '0;
            cnt_q    <= CW'(WIDTH);
            neg_q    <= neg_d;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          {acc_hi_q, mplier_q} <= {sum_co_d, sum_s_d, mplier_q[WIDTH-1:1]};
          cnt_q                <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: begin
          product_q <= product_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
